rv32i_imem_port_arbiter: RTL and testbench
==========================================

Name: rv32i_imem_port_arbiter

Overview:
- Sequences and shares the single instruction-memory port between two requesters: the core's fetch stage (reads) and the external program loader (writes).
- Converts each requester's request/grant handshake into one outstanding memory transaction at a time, using memory request/ack signalling.
- Drops fetch responses invalidated by a branch-miss flush.
- Enforces loader priority with a bounded fetch-starvation guarantee.

Parameters:
- ADDR_W, 32, byte address width on all address ports.
- DATA_W, 32, instruction/data word width.
- STARVE_LIMIT, 4, maximum consecutive loader grants while fetch is waiting before fetch is forced; legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_f_req  in  1  fetch read request; level, held until granted
- i_f_addr  in  ADDR_W  fetch read address
- i_f_flush  in  1  branch miss / flush; kills the pending fetch response
- o_f_gnt  out  1  fetch request accepted this cycle (combinational pulse)
- o_f_rvalid  out  1  fetch read data valid (registered pulse)
- o_f_rdata  out  DATA_W  fetch read data
- i_l_req  in  1  loader write request; level, held until granted
- i_l_addr  in  ADDR_W  loader write address
- i_l_wdata  in  DATA_W  loader write data
- o_l_gnt  out  1  loader request accepted this cycle (combinational pulse)
- o_l_done  out  1  loader write completed (registered pulse)
- o_mem_req  out  1  memory transaction request; held until ack
- o_mem_we  out  1  1 = write, 0 = read
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- i_mem_ack  in  1  memory completion pulse; read data valid in the same cycle
- i_mem_rdata  in  DATA_W  memory read data

Behaviour:
- States: IDLE, BUSY_F, BUSY_L.
  - Also tracked: 4-bit starvation counter `starve_cnt` and 1-bit `drop` flag.
- Reset:
  - State IDLE; `starve_cnt` = 0; `drop` = 0.
  - All outputs 0, including o_mem_addr, o_mem_wdata and o_f_rdata.
  - Reset mid-transaction abandons that transaction with no o_f_rvalid or o_l_done.
  - An i_mem_ack arriving after reset is ignored.
- Arbitration, evaluated only in IDLE:
  - Candidates: fetch = i_f_req && !i_f_flush; loader = i_l_req.
  - Loader wins unless fetch is a candidate and `starve_cnt` == STARVE_LIMIT.
  - Winner's gnt pulses combinationally in that cycle.
  - Registered on the clock edge: o_mem_req=1, o_mem_we (1 for loader), o_mem_addr, o_mem_wdata (loader data; unchanged for fetch).
  - State moves to BUSY_L or BUSY_F.
  - The requester may change or drop its inputs after gnt; the latched values are used.
- Starvation counter:
  - Loader grant while i_f_req=1: increment, saturating at STARVE_LIMIT.
  - Fetch grant: clear to 0.
  - Loader grant while i_f_req=0: clear to 0.
- BUSY_F / BUSY_L:
  - o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata stay stable until i_mem_ack.
  - No gnt is issued while BUSY.
  - On the i_mem_ack cycle: o_mem_req clears next cycle and state returns to IDLE next cycle.
  - BUSY_F, drop=0: o_f_rvalid=1 next cycle with o_f_rdata = i_mem_rdata.
  - BUSY_F, drop=1: no o_f_rvalid.
  - BUSY_L: o_l_done=1 next cycle.
  - Earliest ack is the cycle after the grant.
  - Minimum back-to-back issue: gnt at N, ack at N+1, response and next gnt at N+2.
  - o_f_rdata holds its last value when o_f_rvalid=0.
- Flush:
  - i_f_flush in the BUSY_F state, including its ack cycle, sets `drop`.
  - `drop` clears on the return to IDLE.
  - i_f_flush on the fetch grant cycle is impossible, because flush blocks fetch candidacy.
  - Flush has no effect on BUSY_L or on loader grants.
- Unexpected inputs:
  - i_mem_ack in IDLE is ignored.
  - Address bits [1:0] are passed through unchanged; alignment is the requester's responsibility.
- Throughput: exactly one outstanding memory transaction at any time.

Test Plan:
- Fetch only: i_f_req=1, addr 0x10; memory acks 2 cycles after o_mem_req.
  - Required: o_f_gnt at cycle 0, o_mem_req cycles 1-2, o_mem_we=0.
  - Required: o_f_rvalid at cycle 3 with rdata 0xDEADBEEF matching i_mem_rdata.
- Loader writes 0x0/0x4/0x8 = 0x13/0x93/0x113 with zero-wait ack.
  - Required: each write shows o_mem_we=1 with the correct addr/wdata.
  - Required: o_l_done pulses every 3 cycles, 3 pulses total.
- Starvation, STARVE_LIMIT=4: loader and fetch both request continuously.
  - Required: exactly 4 loader grants, then 1 fetch grant, then the counter restarts.
- Flush, case 1: i_f_flush asserted 1 cycle after o_f_gnt, memory acks 3 cycles later.
  - Required: no o_f_rvalid; next fetch gnt in the cycle after the return to IDLE.
- Flush, case 2: i_f_flush on the ack cycle.
  - Required: response also dropped.
- Reset mid-BUSY_L, then a stray i_mem_ack.
  - Required: all outputs 0 and no o_l_done.
  - Required: a subsequent fetch completes normally.
- Simultaneous requests, `starve_cnt`=0: both requesters assert.
  - Required: o_l_gnt=1, o_f_gnt=0, `starve_cnt` becomes 1.

Source files
------------

// File: rtl/rv32i_imem_port_arbiter.sv
// Shares the single instruction-memory port between the fetch stage (reads) and the
// program loader (writes). Only one memory transaction is outstanding at a time.
module rv32i_imem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_f_req,
   input  logic [ADDR_W-1:0] i_f_addr,
   input  logic              i_f_flush,
   output logic              o_f_gnt,
   output logic              o_f_rvalid,
   output logic [DATA_W-1:0] o_f_rdata,
   input  logic              i_l_req,
   input  logic [ADDR_W-1:0] i_l_addr,
   input  logic [DATA_W-1:0] i_l_wdata,
   output logic              o_l_gnt,
   output logic              o_l_done,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_L} state_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e            state_q, state_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              drop_q, drop_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              f_rvalid_q, f_rvalid_d;
   logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
   logic              l_done_q, l_done_d;

   logic fetchCand;
   logic forceFetch;
   logic fGnt;
   logic lGnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         drop_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         f_rvalid_q   <= 1'b0;
         f_rdata_q    <= '0;
         l_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         drop_q       <= drop_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         f_rvalid_q   <= f_rvalid_d;
         f_rdata_q    <= f_rdata_d;
         l_done_q     <= l_done_d;
      end
   end

   // A flushed fetch is not a candidate; fetch overrides the loader only once starved.
   always_comb begin
      fetchCand    = i_f_req && !i_f_flush;
      forceFetch   = fetchCand && (starve_cnt_q == LIMIT);
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      drop_d       = drop_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      f_rvalid_d   = 1'b0;
      f_rdata_d    = f_rdata_q;
      l_done_d     = 1'b0;
      fGnt         = 1'b0;
      lGnt         = 1'b0;

      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (i_l_req && !forceFetch) begin
               lGnt        = 1'b1;
               state_d     = BUSY_L;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = i_l_addr;
               mem_wdata_d = i_l_wdata;
               if (!i_f_req) begin
                  starve_cnt_d = '0;
               end else if (starve_cnt_q < LIMIT) begin
                  starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end else if (fetchCand) begin
               fGnt         = 1'b1;
               state_d      = BUSY_F;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = i_f_addr;
               starve_cnt_d = '0;
            end
         end
         BUSY_F: begin
            if (i_f_flush) begin
               drop_d = 1'b1;
            end
            if (i_mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               drop_d    = 1'b0;
               // A flush arriving on the ack cycle itself still kills the response.
               if (!(drop_q || i_f_flush)) begin
                  f_rvalid_d = 1'b1;
                  f_rdata_d  = i_mem_rdata;
               end
            end
         end
         BUSY_L: begin
            if (i_mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               l_done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_f_gnt     = fGnt && !i_rst;
   assign o_l_gnt     = lGnt && !i_rst;
   assign o_f_rvalid  = f_rvalid_q;
   assign o_f_rdata   = f_rdata_q;
   assign o_l_done    = l_done_q;
   assign o_mem_req   = mem_req_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rv32i_imem_port_arbiter.sv
// Directed bench for rv32i_imem_port_arbiter: a transaction-level model is compared with
// the DUT every cycle, and hand-computed expectations pin timing and arbitration order.
module tb_rv32i_imem_port_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;

   logic              i_clk;
   logic              i_rst;
   logic              i_f_req;
   logic [ADDR_W-1:0] i_f_addr;
   logic              i_f_flush;
   logic              o_f_gnt;
   logic              o_f_rvalid;
   logic [DATA_W-1:0] o_f_rdata;
   logic              i_l_req;
   logic [ADDR_W-1:0] i_l_addr;
   logic [DATA_W-1:0] i_l_wdata;
   logic              o_l_gnt;
   logic              o_l_done;
   logic              o_mem_req;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic              i_mem_ack;
   logic [DATA_W-1:0] i_mem_rdata;

   rv32i_imem_port_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_f_req(i_f_req),
      .i_f_addr(i_f_addr),
      .i_f_flush(i_f_flush),
      .o_f_gnt(o_f_gnt),
      .o_f_rvalid(o_f_rvalid),
      .o_f_rdata(o_f_rdata),
      .i_l_req(i_l_req),
      .i_l_addr(i_l_addr),
      .i_l_wdata(i_l_wdata),
      .o_l_gnt(o_l_gnt),
      .o_l_done(o_l_done),
      .o_mem_req(o_mem_req),
      .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata),
      .i_mem_ack(i_mem_ack),
      .i_mem_rdata(i_mem_rdata)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit chkEn  = 0;

   // Memory responder controls
   int memWait  = 0;
   int memAge   = 0;
   bit memAuto  = 1;
   bit strayAck = 0;

   // Transaction-level model state
   bit          mBusy   = 0;
   bit          mWrite  = 0;
   bit          mDrop   = 0;
   logic [31:0] mAddr   = '0;
   logic [31:0] mWdata  = '0;
   int          mStarve = 0;
   bit          mRvalid = 0;
   logic [31:0] mRdata  = '0;
   bit          mDone   = 0;

   // Event log
   int          gntQ[$];
   int          doneCycQ[$];
   int          lastFGntCyc = 0;
   int          lastAckCyc  = 0;
   int          lastRvalidCyc = 0;
   int          rvalidCount = 0;
   int          ackCount    = 0;
   logic [31:0] lastRdata   = '0;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] memData(input logic [31:0] addr);
      if (addr == 32'h10) return 32'hDEADBEEF;
      return {addr[15:0], 16'hC0DE};
   endfunction

   // 0 = no grant, 1 = fetch, 2 = loader
   function automatic int pickWinner();
      bit fC;
      if (i_rst || mBusy) return 0;
      fC = i_f_req && !i_f_flush;
      if (fC && (!i_l_req || mStarve == STARVE_LIMIT)) return 1;
      if (i_l_req) return 2;
      return 0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic applyStimulus(input bit fReq, input logic [31:0] fAddr, input bit flush,
                                input bit lReq, input logic [31:0] lAddr, input logic [31:0] lData);
      i_f_req   = fReq;
      i_f_addr  = fAddr;
      i_f_flush = flush;
      i_l_req   = lReq;
      i_l_addr  = lAddr;
      i_l_wdata = lData;
   endtask

   task automatic applyReset();
      applyStimulus(0, 0, 0, 0, 0, 0);
      i_rst = 1'b1;
      repeat (2) tick();
      i_rst = 1'b0;
   endtask

   // sel: 0 f_gnt, 1 l_gnt, 2 l_done, 3 f_rvalid; returns at the negedge it was seen
   task automatic waitSignal(input int sel, input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge i_clk);
         case (sel)
            0: seen = o_f_gnt;
            1: seen = o_l_gnt;
            2: seen = o_l_done;
            default: seen = o_f_rvalid;
         endcase
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_%s: got timeout required event within 64 cycles", name);
      end
   endtask

   always @(posedge i_clk) cyc <= cyc + 1;

   // Memory: acks after memWait extra cycles of o_mem_req; driven off the edge
   always @(posedge i_clk) begin
      #2;
      if (!memAuto) begin
         i_mem_ack = strayAck;
         memAge    = 0;
      end else if (o_mem_req) begin
         if (memAge == memWait) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = memData(o_mem_addr);
            memAge      = 0;
         end else begin
            i_mem_ack = 1'b0;
            memAge++;
         end
      end else begin
         i_mem_ack = 1'b0;
         memAge    = 0;
      end
   end

   // Reference model advances one transaction step per clock edge
   always @(posedge i_clk) begin
      int w;
      w = pickWinner();
      if (i_rst) begin
         mBusy = 0; mWrite = 0; mDrop = 0; mAddr = '0; mWdata = '0;
         mStarve = 0; mRvalid = 0; mRdata = '0; mDone = 0;
      end else begin
         mRvalid = 0;
         mDone   = 0;
         if (mBusy) begin
            if (i_f_flush && !mWrite) mDrop = 1;
            if (i_mem_ack) begin
               mBusy = 0;
               if (mWrite) mDone = 1;
               else if (!mDrop) begin
                  mRvalid = 1;
                  mRdata  = i_mem_rdata;
               end
               mDrop = 0;
            end
         end else if (w == 1) begin
            mBusy = 1; mWrite = 0; mAddr = i_f_addr; mStarve = 0;
         end else if (w == 2) begin
            mBusy = 1; mWrite = 1; mAddr = i_l_addr; mWdata = i_l_wdata;
            if (!i_f_req) mStarve = 0;
            else if (mStarve < STARVE_LIMIT) mStarve = mStarve + 1;
         end
      end
   end

   // Compare DUT against the model every cycle and log events for the directed checks
   always @(negedge i_clk) begin
      int w;
      w = pickWinner();
      if (chkEn) begin
         checkOutput("f_gnt",     32'(o_f_gnt),    32'(w == 1));
         checkOutput("l_gnt",     32'(o_l_gnt),    32'(w == 2));
         checkOutput("mem_req",   32'(o_mem_req),  32'(mBusy));
         checkOutput("mem_we",    32'(o_mem_we),   32'(mWrite));
         checkOutput("mem_addr",  o_mem_addr,      mAddr);
         checkOutput("mem_wdata", o_mem_wdata,     mWdata);
         checkOutput("f_rvalid",  32'(o_f_rvalid), 32'(mRvalid));
         checkOutput("f_rdata",   o_f_rdata,       mRdata);
         checkOutput("l_done",    32'(o_l_done),   32'(mDone));
      end
      if (o_f_gnt) begin gntQ.push_back(1); lastFGntCyc = cyc; end
      if (o_l_gnt) gntQ.push_back(2);
      if (i_mem_ack) begin lastAckCyc = cyc; ackCount++; end
      if (o_f_rvalid) begin rvalidCount++; lastRvalidCyc = cyc; lastRdata = o_f_rdata; end
      if (o_l_done) doneCycQ.push_back(cyc);
   end

   initial begin
      int base;
      int baseAck;
      int fGntCyc;
      logic [31:0] loadAddr [3];
      logic [31:0] loadData [3];
      loadAddr[0] = 32'h0; loadAddr[1] = 32'h4;  loadAddr[2] = 32'h8;
      loadData[0] = 32'h13; loadData[1] = 32'h93; loadData[2] = 32'h113;
      i_rst = 1'b1;
      i_mem_ack = 1'b0;
      i_mem_rdata = '0;
      applyReset();
      chkEn = 1;

      // Reset state
      checkOutput("reset_mem_req", 32'(o_mem_req), 32'h0);
      checkOutput("reset_mem_addr", o_mem_addr, 32'h0);
      checkOutput("reset_f_rdata", o_f_rdata, 32'h0);

      // Fetch only, memory acks on the second o_mem_req cycle
      memWait = 1;
      applyStimulus(1, 32'h10, 0, 0, 0, 0);
      waitSignal(0, "fetch1_gnt");
      tick();
      fGntCyc = lastFGntCyc;
      i_f_req = 0;
      waitSignal(3, "fetch1_rvalid");
      tick();
      checkOutput("fetch1_latency", 32'(lastRvalidCyc - fGntCyc), 32'd3);
      checkOutput("fetch1_rdata", lastRdata, 32'hDEADBEEF);

      // Three loader writes, zero-wait ack, requester re-arms after each done
      memWait = 0;
      base = doneCycQ.size();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, 1, loadAddr[k], loadData[k]);
         waitSignal(1, "load_gnt");
         tick();
         i_l_req = 0;
         waitSignal(2, "load_done");
         tick();
      end
      checkOutput("load_done_count", 32'(doneCycQ.size() - base), 32'd3);
      checkOutput("load_done_gap1", 32'(doneCycQ[base+1] - doneCycQ[base]), 32'd3);
      checkOutput("load_done_gap2", 32'(doneCycQ[base+2] - doneCycQ[base+1]), 32'd3);

      // Starvation: both request continuously
      applyReset();
      memWait = 0;
      base = gntQ.size();
      applyStimulus(1, 32'h40, 0, 1, 32'h100, 32'h55);
      repeat (12) tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (4) tick();
      checkOutput("starve_g0", 32'(gntQ[base+0]), 32'd2);
      checkOutput("starve_g1", 32'(gntQ[base+1]), 32'd2);
      checkOutput("starve_g2", 32'(gntQ[base+2]), 32'd2);
      checkOutput("starve_g3", 32'(gntQ[base+3]), 32'd2);
      checkOutput("starve_g4", 32'(gntQ[base+4]), 32'd1);
      checkOutput("starve_g5", 32'(gntQ[base+5]), 32'd2);

      // Flush one cycle after the fetch grant, ack three cycles later
      applyReset();
      memWait = 3;
      base = rvalidCount;
      applyStimulus(1, 32'h20, 0, 0, 0, 0);
      waitSignal(0, "flush1_gnt");
      tick();
      i_f_flush = 1;
      i_f_addr  = 32'h24;
      tick();
      i_f_flush = 0;
      waitSignal(0, "flush1_regnt");
      tick();
      i_f_req = 0;
      checkOutput("flush1_no_rvalid", 32'(rvalidCount - base), 32'd0);
      checkOutput("flush1_regnt_cycle", 32'(lastFGntCyc - lastAckCyc), 32'd1);
      waitSignal(3, "flush1_rvalid");
      tick();
      checkOutput("flush1_refetch_rdata", lastRdata, memData(32'h24));

      // Flush on the ack cycle
      memWait = 2;
      base = rvalidCount;
      baseAck = ackCount;
      applyStimulus(1, 32'h30, 0, 0, 0, 0);
      waitSignal(0, "flush2_gnt");
      tick();
      i_f_req = 0;
      tick();
      tick();
      i_f_flush = 1;
      tick();
      i_f_flush = 0;
      repeat (3) tick();
      checkOutput("flush2_acked", 32'(ackCount - baseAck), 32'd1);
      checkOutput("flush2_no_rvalid", 32'(rvalidCount - base), 32'd0);

      // Reset in the middle of a loader write, then a stray ack
      memWait = 6;
      base = doneCycQ.size();
      applyStimulus(0, 0, 0, 1, 32'h200, 32'hAB);
      waitSignal(1, "rst_gnt");
      tick();
      i_l_req = 0;
      tick();
      i_rst = 1;
      tick();
      i_rst    = 0;
      memAuto  = 0;
      strayAck = 1;
      checkOutput("rst_mem_req", 32'(o_mem_req), 32'h0);
      checkOutput("rst_mem_we", 32'(o_mem_we), 32'h0);
      checkOutput("rst_mem_addr", o_mem_addr, 32'h0);
      checkOutput("rst_mem_wdata", o_mem_wdata, 32'h0);
      checkOutput("rst_f_rdata", o_f_rdata, 32'h0);
      tick();
      strayAck = 0;
      tick();
      memAuto = 1;
      repeat (3) tick();
      checkOutput("rst_no_done", 32'(doneCycQ.size() - base), 32'd0);
      checkOutput("rst_stray_idle", 32'(o_mem_req), 32'h0);
      memWait = 1;
      base = rvalidCount;
      applyStimulus(1, 32'h10, 0, 0, 0, 0);
      waitSignal(0, "rst_fetch_gnt");
      tick();
      i_f_req = 0;
      waitSignal(3, "rst_fetch_rvalid");
      tick();
      checkOutput("rst_fetch_count", 32'(rvalidCount - base), 32'd1);
      checkOutput("rst_fetch_rdata", lastRdata, 32'hDEADBEEF);

      // Simultaneous requests from a cleared starvation counter
      applyReset();
      memWait = 0;
      applyStimulus(1, 32'h50, 0, 1, 32'h300, 32'h77);
      @(negedge i_clk);
      checkOutput("sim_l_gnt", 32'(o_l_gnt), 32'h1);
      checkOutput("sim_f_gnt", 32'(o_f_gnt), 32'h0);
      tick();
      i_l_req = 0;
      checkOutput("sim_starve_cnt", 32'(dut.starve_cnt_q), 32'd1);
      checkOutput("sim_model_starve", 32'(mStarve), 32'd1);
      waitSignal(0, "sim_fetch_gnt");
      tick();
      i_f_req = 0;
      waitSignal(3, "sim_fetch_rvalid");
      tick();
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
